riscv_dmem_load_combiner: RTL and testbench
===========================================

// Module: riscv_dmem_load_combiner
// PURPOSE
//  Parametrised load-data path between the data-memory response and the register-file writeback.
//  It rotates, byte-merges and sign/zero-extends load data, as the single-cycle read-data block does.
//  New over that block: loads that cross a memory-word boundary run as two sequential beats.
//  Load and output use a valid/ready handshake, and an optional mode traps crossing loads instead.
// PARAMETERS
//  DATA_BYTES     4  bytes per memory word and result (4 or 8); DW = 8*DATA_BYTES, AW = log2(DATA_BYTES)
//  MISALIGN_TRAP  0  1: word-crossing load completes at once with out_error=1, no memory beat issued
// PORTS
//  clk             in   1    clock, all state on rising edge
//  reset           in   1    asynchronous, active-high
//  req_valid       in   1    load request present
//  req_ready       out  1    block idle, request accepted when req_valid&req_ready
//  req_addr_lo     in   AW   byte offset of load within memory word
//  req_size        in   2    0 byte, 1 half, 2 word, 3 dword (3 legal only if DATA_BYTES==8)
//  req_signed      in   1    1 sign-extend, 0 zero-extend
//  mem_req_valid   out  1    memory beat requested
//  mem_req_beat    out  1    0 first word, 1 next word (address+DATA_BYTES, owner computes)
//  mem_resp_valid  in   1    memory data for the outstanding beat (the inverse of wait)
//  mem_resp_data   in   DW   raw memory word
//  out_valid       out  1    result available
//  out_ready       in   1    writeback accepts result
//  out_data        out  DW   aligned, merged, extended load data
//  out_error       out  1    illegal size or trapped crossing load; out_data=0 when set
// BEHAVIOUR
//  - States: IDLE, BEAT0, BEAT1, DONE. Reset -> IDLE.
//  - Reset values: req_ready=1, mem_req_valid=0, mem_req_beat=0, out_valid=0, out_error=0, out_data=0.
//  - Definitions: nbytes = 1<<req_size; crossing = (addr_lo + nbytes) > DATA_BYTES.
//    Size, offset and sign are captured at acceptance and held until DONE exits.
//  - IDLE: on accept, an illegal size, or crossing with MISALIGN_TRAP=1, goes to DONE with out_error=1.
//    Otherwise it goes to BEAT0. req_ready=1 only in IDLE.
//  - BEAT0: mem_req_valid=1, beat=0, held until mem_resp_valid.
//    The response is rotated right by 8*addr_lo and its low (DATA_BYTES-addr_lo) bytes enter the merge register.
//    Crossing -> BEAT1, else -> DONE.
//  - BEAT1: mem_req_valid=1, beat=1, until mem_resp_valid. The response is rotated right by the same 8*addr_lo.
//    Bytes [DATA_BYTES-addr_lo .. nbytes-1] are merged over it and the state goes to DONE.
//    Bytes from beat 0 are never overwritten.
//  - Extension is applied on entry to DONE:
//    - bytes >= nbytes are cleared;
//    - if req_signed, they are filled with bit 8*nbytes-1.
//    - A full-width load is unextended.
//  - DONE: out_valid=1 and out_data/out_error are held stable until out_ready.
//    On out_valid&out_ready the block returns to IDLE. A new request is accepted no earlier than the next cycle.
//  - Latency: aligned load gives out_valid 1 cycle after the response edge; crossing gives it 1 cycle after the beat-1 response.
//    Trap/illegal gives out_valid the cycle after acceptance.
//  - mem_resp_valid in IDLE or DONE is ignored and does not change state.
//    mem_req_* is combinational from state only.
//  - Reset mid-operation, in any state, returns immediately to IDLE with reset values.
//    An in-flight beat is abandoned and no output is produced for it.
//  - out_ready held low keeps DONE indefinitely, with no data change.
//  - out_valid and out_error are registered.
// TESTING
//  1. DATA_BYTES=4, addr_lo=1, size=0, signed, resp=32'h1234_8056
//     -> one beat, out_data=32'hFFFF_FF80, out_error=0.
//  2. addr_lo=3, size=1, unsigned; beat0=32'hAB00_0000, beat1=32'h0000_00CD
//     -> two beats (beat 0 then 1), out_data=32'h0000_CDAB.
//  3. Same as 2 with MISALIGN_TRAP=1 -> no mem_req_valid, out_valid next cycle, out_error=1, out_data=0.
//  4. addr_lo=2, size=2; out_ready=0 for 5 cycles after out_valid
//     -> out_data stable (beat0[31:16] | beat1[15:0]<<16), req_ready=0 throughout.
//  5. reset pulsed while in BEAT1
//     -> IDLE, req_ready=1, no out_valid. Next aligned word load (resp 32'hDEAD_BEEF) returns 32'hDEAD_BEEF.
//  6. DATA_BYTES=8, addr_lo=6, size=2, signed; beat0=64'hFF80_xxxx.., beat1 low bytes 16'h8001
//     -> out_data=64'hFFFF_FFFF_8001_FF80. With size=3 on DATA_BYTES=4, out_error=1.

Source files
------------

// File: rtl/riscv_dmem_load_combiner_if.sv
// Load-combiner bus: load request, memory beat request/response and writeback result.
// The slave modport is the combiner; the master modport is the core/memory environment.
interface riscv_dmem_load_combiner_if #(
  parameter int unsigned DATA_BYTES = 4
);
  localparam int unsigned AW = $clog2(DATA_BYTES);
  localparam int unsigned DW = 8 * DATA_BYTES;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr_lo;
  logic [1:0]    req_size;
  logic          req_signed;
  logic          mem_req_valid;
  logic          mem_req_beat;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_error;

  modport master (
    output req_valid, req_addr_lo, req_size, req_signed, mem_resp_valid, mem_resp_data,
    output out_ready,
    input  req_ready, mem_req_valid, mem_req_beat, out_valid, out_data, out_error
  );

  modport slave (
    input  req_valid, req_addr_lo, req_size, req_signed, mem_resp_valid, mem_resp_data,
    input  out_ready,
    output req_ready, mem_req_valid, mem_req_beat, out_valid, out_data, out_error
  );
endinterface

// File: rtl/riscv_dmem_load_combiner.sv
// Load-data path: rotates, merges (one or two memory beats) and sign/zero-extends load data,
// with valid/ready handshakes on the request and the writeback result.
module riscv_dmem_load_combiner #(
  parameter int unsigned DATA_BYTES    = 4,
  parameter bit          MISALIGN_TRAP = 1'b0
) (
  input logic                        clk,
  input logic                        reset,
  riscv_dmem_load_combiner_if.slave  bus
);
  localparam int unsigned AW = $clog2(DATA_BYTES);
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int          DB = int'(DATA_BYTES);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;

  state_e        state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] offset_q, offset_d;
  logic          signed_q, signed_d;
  logic [DW-1:0] merge_q, merge_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic [DW-1:0] rot;
  int            nb_q;
  logic          cross_q;

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic crossing(input logic [AW-1:0] off, input logic [1:0] size);
    return (int'(off) + nbytes(size)) > DB;
  endfunction

  // Byte i of the result is byte (i + off) mod DATA_BYTES of the memory word.
  function automatic logic [DW-1:0] rotate(input logic [DW-1:0] word, input logic [AW-1:0] off);
    logic [DW-1:0] res;
    logic [AW-1:0] idx;
    res = '0;
    for (int i = 0; i < DB; i++) begin
      idx = AW'(i) + off;
      res[8*i +: 8] = word[8*int'(idx) +: 8];
    end
    return res;
  endfunction

  // Full-width loads fall through untouched since no byte lies at or above nb.
  function automatic logic [DW-1:0] extend(input logic [DW-1:0] data, input logic [1:0] size,
                                           input logic sgn);
    logic [DW-1:0] res;
    int            nb;
    logic          sign;
    nb = nbytes(size);
    if (nb > DB) nb = DB;
    sign = data[8*nb-1];
    res = data;
    for (int i = 0; i < DB; i++) begin
      if (i >= nb) res[8*i +: 8] = (sgn && sign) ? 8'hFF : 8'h00;
    end
    return res;
  endfunction

  assign rot     = rotate(bus.mem_resp_data, offset_q);
  assign nb_q    = nbytes(size_q);
  assign cross_q = crossing(offset_q, size_q);

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    offset_d = offset_q;
    signed_d = signed_q;
    merge_d  = merge_q;
    data_d   = data_q;
    valid_d  = valid_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          size_d   = bus.req_size;
          offset_d = bus.req_addr_lo;
          signed_d = bus.req_signed;
          if ((nbytes(bus.req_size) > DB) ||
              (MISALIGN_TRAP && crossing(bus.req_addr_lo, bus.req_size))) begin
            state_d = StDone;
            valid_d = 1'b1;
            error_d = 1'b1;
            data_d  = '0;
          end else begin
            state_d = StBeat0;
          end
        end
      end
      StBeat0: begin
        if (bus.mem_resp_valid) begin
          for (int i = 0; i < DB; i++) begin
            merge_d[8*i +: 8] = (i < DB - int'(offset_q)) ? rot[8*i +: 8] : 8'h00;
          end
          if (cross_q) begin
            state_d = StBeat1;
          end else begin
            state_d = StDone;
            valid_d = 1'b1;
            error_d = 1'b0;
            data_d  = extend(merge_d, size_q, signed_q);
          end
        end
      end
      StBeat1: begin
        if (bus.mem_resp_valid) begin
          // Only the bytes beat 0 could not supply are taken from the second word.
          for (int i = 0; i < DB; i++) begin
            if (i >= DB - int'(offset_q) && i < nb_q) merge_d[8*i +: 8] = rot[8*i +: 8];
          end
          state_d = StDone;
          valid_d = 1'b1;
          error_d = 1'b0;
          data_d  = extend(merge_d, size_q, signed_q);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      size_q   <= '0;
      offset_q <= '0;
      signed_q <= 1'b0;
      merge_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      offset_q <= offset_d;
      signed_q <= signed_d;
      merge_q  <= merge_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign bus.req_ready     = (state_q == StIdle);
  assign bus.mem_req_valid = (state_q == StBeat0) || (state_q == StBeat1);
  assign bus.mem_req_beat  = (state_q == StBeat1);
  assign bus.out_valid     = valid_q;
  assign bus.out_error     = error_q;
  assign bus.out_data      = data_q;
endmodule

// File: tb/tb_riscv_dmem_load_combiner.sv
// Bench for riscv_dmem_load_combiner: three instances (4-byte, 4-byte trapping, 8-byte)
// driven through a shared stimulus port selected by sel, checked against a byte-level model.
module tb_riscv_dmem_load_combiner;
  logic        clk = 1'b0;
  logic        reset;
  int          sel;
  logic        req_valid, req_signed, mem_resp_valid, out_ready;
  logic [2:0]  req_addr_lo;
  logic [1:0]  req_size;
  logic [63:0] mem_resp_data;
  logic        req_ready, mem_req_valid, mem_req_beat, out_valid, out_error;
  logic [63:0] out_data;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  riscv_dmem_load_combiner_if #(.DATA_BYTES(4)) bus_a ();
  riscv_dmem_load_combiner_if #(.DATA_BYTES(4)) bus_t ();
  riscv_dmem_load_combiner_if #(.DATA_BYTES(8)) bus_w ();

  assign bus_a.req_valid      = req_valid && (sel == 0);
  assign bus_a.req_addr_lo    = req_addr_lo[1:0];
  assign bus_a.req_size       = req_size;
  assign bus_a.req_signed     = req_signed;
  assign bus_a.mem_resp_valid = mem_resp_valid && (sel == 0);
  assign bus_a.mem_resp_data  = mem_resp_data[31:0];
  assign bus_a.out_ready      = out_ready;
  assign bus_t.req_valid      = req_valid && (sel == 1);
  assign bus_t.req_addr_lo    = req_addr_lo[1:0];
  assign bus_t.req_size       = req_size;
  assign bus_t.req_signed     = req_signed;
  assign bus_t.mem_resp_valid = mem_resp_valid && (sel == 1);
  assign bus_t.mem_resp_data  = mem_resp_data[31:0];
  assign bus_t.out_ready      = out_ready;
  assign bus_w.req_valid      = req_valid && (sel == 2);
  assign bus_w.req_addr_lo    = req_addr_lo;
  assign bus_w.req_size       = req_size;
  assign bus_w.req_signed     = req_signed;
  assign bus_w.mem_resp_valid = mem_resp_valid && (sel == 2);
  assign bus_w.mem_resp_data  = mem_resp_data;
  assign bus_w.out_ready      = out_ready;

  riscv_dmem_load_combiner #(.DATA_BYTES(4), .MISALIGN_TRAP(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  riscv_dmem_load_combiner #(.DATA_BYTES(4), .MISALIGN_TRAP(1'b1)) dut_t (
    .clk(clk), .reset(reset), .bus(bus_t));
  riscv_dmem_load_combiner #(.DATA_BYTES(8), .MISALIGN_TRAP(1'b0)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w));

  always_comb begin
    req_ready     = bus_a.req_ready;
    mem_req_valid = bus_a.mem_req_valid;
    mem_req_beat  = bus_a.mem_req_beat;
    out_valid     = bus_a.out_valid;
    out_error     = bus_a.out_error;
    out_data      = {32'h0, bus_a.out_data};
    if (sel == 1) begin
      req_ready     = bus_t.req_ready;
      mem_req_valid = bus_t.mem_req_valid;
      mem_req_beat  = bus_t.mem_req_beat;
      out_valid     = bus_t.out_valid;
      out_error     = bus_t.out_error;
      out_data      = {32'h0, bus_t.out_data};
    end else if (sel == 2) begin
      req_ready     = bus_w.req_ready;
      mem_req_valid = bus_w.mem_req_valid;
      mem_req_beat  = bus_w.mem_req_beat;
      out_valid     = bus_w.out_valid;
      out_error     = bus_w.out_error;
      out_data      = bus_w.out_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory seen as a byte array: word 0 followed by word 1; the load reads bytes a..a+nb-1.
  function automatic void model(input int s, input int a, input int sz, input bit sg,
                                input logic [63:0] b0, input logic [63:0] b1,
                                output logic [63:0] d, output logic e, output int seq);
    int         db;
    int         nb;
    logic [7:0] mem [16];
    db  = (s == 2) ? 8 : 4;
    nb  = 1 << sz;
    d   = '0;
    e   = 1'b0;
    seq = 0;
    if (nb > db || (s == 1 && a + nb > db)) begin
      e = 1'b1;
      return;
    end
    for (int k = 0; k < db; k++) begin
      mem[k]      = b0[8*k +: 8];
      mem[k + db] = b1[8*k +: 8];
    end
    for (int i = 0; i < nb; i++) d[8*i +: 8] = mem[a + i];
    if (sg && nb < db && d[8*nb-1]) begin
      for (int i = nb; i < db; i++) d[8*i +: 8] = 8'hFF;
    end
    seq = (a + nb > db) ? 12 : 1;
  endfunction

  // seq encodes beats in order (beat 0 -> 1, beat 0 then 1 -> 12); lat counts negedges
  // from the last handshake (accept or memory response) to the first out_valid.
  task automatic run_load(input int s, input int a, input int sz, input bit sg,
                          input logic [63:0] b0, input logic [63:0] b1, input int hold,
                          output logic [63:0] d, output logic e, output int seq,
                          output int lat);
    int guard;
    bit done;
    sel = s;
    seq = 0;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_addr_lo = 3'(a);
    req_size    = 2'(sz);
    req_signed  = sg;
    @(negedge clk);
    req_valid = 1'b0;
    lat   = 1;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      if (out_valid) begin
        done = 1'b1;
      end else if (guard >= 40) begin
        check("out_valid_timeout", 64'(out_valid), 64'd1);
        done = 1'b1;
      end else begin
        guard++;
        if (mem_req_valid && $urandom_range(0, 3) != 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_req_beat ? b1 : b0;
          seq = seq * 10 + int'(mem_req_beat) + 1;
          lat = 0;
        end else begin
          mem_resp_valid = 1'b0;
          mem_resp_data  = {$urandom, $urandom};
        end
        @(negedge clk);
        lat++;
      end
    end
    mem_resp_valid = 1'b0;
    d = out_data;
    e = out_error;
    for (int h = 0; h < hold; h++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {$urandom, $urandom};
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_data, d);
      check("hold_error", 64'(out_error), 64'(e));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    mem_resp_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d, md, b0, b1;
    logic        e, me;
    int          seq, mseq, lat, s, a, sz, hold;
    bit          sg;

    reset = 1'b1; sel = 0; req_valid = 1'b0; req_signed = 1'b0; req_addr_lo = '0;
    req_size = '0; mem_resp_valid = 1'b0; mem_resp_data = '0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_mem_req_beat", 64'(mem_req_beat), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_error", 64'(out_error), 64'd0);
      check("rst_out_data", out_data, 64'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Memory responses in IDLE are ignored.
    sel = 0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h1111_2222_3333_4444;
    repeat (3) @(negedge clk);
    mem_resp_valid = 1'b0;
    check("idle_resp_req_ready", 64'(req_ready), 64'd1);
    check("idle_resp_mem_req", 64'(mem_req_valid), 64'd0);
    check("idle_resp_out_valid", 64'(out_valid), 64'd0);

    // Signed byte at offset 1.
    run_load(0, 1, 0, 1'b1, 64'h1234_8056, 64'h0, 0, d, e, seq, lat);
    check("t1_data", d, 64'hFFFF_FF80);
    check("t1_error", 64'(e), 64'd0);
    check("t1_seq", 64'(seq), 64'd1);
    check("t1_lat", 64'(lat), 64'd1);

    // Crossing halfword, two beats.
    run_load(0, 3, 1, 1'b0, 64'hAB00_0000, 64'h0000_00CD, 1, d, e, seq, lat);
    check("t2_data", d, 64'h0000_CDAB);
    check("t2_error", 64'(e), 64'd0);
    check("t2_seq", 64'(seq), 64'd12);
    check("t2_lat", 64'(lat), 64'd1);

    // Same load trapped.
    run_load(1, 3, 1, 1'b0, 64'hAB00_0000, 64'h0000_00CD, 1, d, e, seq, lat);
    check("t3_data", d, 64'h0);
    check("t3_error", 64'(e), 64'd1);
    check("t3_seq", 64'(seq), 64'd0);
    check("t3_lat", 64'(lat), 64'd1);

    // Crossing word with writeback stalled five cycles.
    run_load(0, 2, 2, 1'b1, 64'hAABB_CCDD, 64'h1122_3344, 5, d, e, seq, lat);
    check("t4_data", d, 64'h3344_AABB);
    check("t4_error", 64'(e), 64'd0);
    check("t4_seq", 64'(seq), 64'd12);

    // Reset while in the second beat.
    sel = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr_lo = 3'd3; req_size = 2'd1; req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_beat0", 64'(mem_req_beat), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hAB00_0000;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("t5_in_beat1", 64'(mem_req_beat), 64'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_req_ready", 64'(req_ready), 64'd1);
    check("t5_rst_mem_req", 64'(mem_req_valid), 64'd0);
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_out_valid", 64'(out_valid), 64'd0);
    run_load(0, 0, 2, 1'b0, 64'hDEAD_BEEF, 64'h0, 0, d, e, seq, lat);
    check("t5_data", d, 64'hDEAD_BEEF);
    check("t5_error", 64'(e), 64'd0);

    // 8-byte word: signed crossing word at offset 6.
    run_load(2, 6, 2, 1'b1, 64'hFF80_1234_5678_9ABC, 64'h0123_4567_89AB_8001, 0,
             d, e, seq, lat);
    check("t6_data", d, 64'hFFFF_FFFF_8001_FF80);
    check("t6_error", 64'(e), 64'd0);
    check("t6_seq", 64'(seq), 64'd12);

    // Doubleword on a 4-byte word is illegal.
    run_load(0, 0, 3, 1'b0, 64'h5555_5555, 64'h0, 0, d, e, seq, lat);
    check("t6_illegal_data", d, 64'h0);
    check("t6_illegal_error", 64'(e), 64'd1);
    check("t6_illegal_seq", 64'(seq), 64'd0);

    for (int it = 0; it < 60; it++) begin
      s    = int'($urandom_range(0, 2));
      a    = int'($urandom_range(0, (s == 2) ? 7 : 3));
      sz   = int'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      b0   = {$urandom, $urandom};
      b1   = {$urandom, $urandom};
      hold = int'($urandom_range(0, 3));
      run_load(s, a, sz, sg, b0, b1, hold, d, e, seq, lat);
      model(s, a, sz, sg, b0, b1, md, me, mseq);
      check("rnd_data", d, md);
      check("rnd_error", 64'(e), 64'(me));
      check("rnd_seq", 64'(seq), 64'(mseq));
      check("rnd_lat", 64'(lat), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
